// File: rtl/fpu_mul_sched_pkg.sv
// ----------------------------------------------------------------------------
// fpu_mul_sched_pkg
// Shared definitions for the two-port FP32 multiply scheduler: FP32 field
// widths, exponent bias, special-value patterns and the port identifier type.
// No ports (package).
// ----------------------------------------------------------------------------
package fpu_mul_sched_pkg;

   localparam int FP_W   = 32;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = FRAC_W + 1;     // fraction plus the hidden one
   localparam int PROD_W = 2 * MANT_W;     // full mantissa product width
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
   localparam logic [FP_W-1:0]  FP_INF   = 32'h7F80_0000;
   localparam logic [FP_W-1:0]  FP_ZERO  = 32'h0000_0000;

   // Identifies which requester port an operation belongs to
   typedef logic port_id_t;
   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   // Biased exponent field of an FP32 word
   function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
      return v[FP_W-2 -: EXP_W];
   endfunction

endpackage

// File: rtl/fpu_mul_sched_if.sv
// ----------------------------------------------------------------------------
// fpu_mul_sched_if
// Bundle of the two request ports, the two response ports and the busy flag.
//   master : requester side (drives reqN_valid/srca/srcb/tag, sees the rest)
//   slave  : scheduler side (drives reqN_ready, rspN_*, busy)
// Parameter TAGW : width of the requester tag.
// ----------------------------------------------------------------------------
interface fpu_mul_sched_if
   import fpu_mul_sched_pkg::*;
#(
   parameter int TAGW = 4
);

   logic             req0_valid;
   logic             req0_ready;
   logic [FP_W-1:0]  req0_srca;
   logic [FP_W-1:0]  req0_srcb;
   logic [TAGW-1:0]  req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [FP_W-1:0]  req1_srca;
   logic [FP_W-1:0]  req1_srcb;
   logic [TAGW-1:0]  req1_tag;

   logic             rsp0_valid;
   logic [FP_W-1:0]  rsp0_dst;
   logic [TAGW-1:0]  rsp0_tag;

   logic             rsp1_valid;
   logic [FP_W-1:0]  rsp1_dst;
   logic [TAGW-1:0]  rsp1_tag;

   logic             busy;

   modport master (
      output req0_valid, req0_srca, req0_srcb, req0_tag,
      output req1_valid, req1_srca, req1_srcb, req1_tag,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_dst, rsp0_tag,
      input  rsp1_valid, rsp1_dst, rsp1_tag,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_srca, req0_srcb, req0_tag,
      input  req1_valid, req1_srca, req1_srcb, req1_tag,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_dst, rsp0_tag,
      output rsp1_valid, rsp1_dst, rsp1_tag,
      output busy
   );

endinterface

// File: rtl/fpu_mul_core.sv
// ----------------------------------------------------------------------------
// fpu_mul_core
// Combinational FP32 multiply with truncated fraction and flush-to-zero.
//   srca, srcb : FP32 operands
//   dst        : FP32 product (zero on underflow or zero-exponent input,
//                signed infinity on overflow or max-exponent input)
// ----------------------------------------------------------------------------
module fpu_mul_core
   import fpu_mul_sched_pkg::*;
(
   input  logic [FP_W-1:0] srca,
   input  logic [FP_W-1:0] srcb,
   output logic [FP_W-1:0] dst
);

   localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
   localparam logic signed [9:0] BIAS_M1_S = 10'(BIAS - 1);

   logic                    sign_s;
   logic [EXP_W-1:0]        ea_s;
   logic [EXP_W-1:0]        eb_s;
   logic [PROD_W-1:0]       prod_s;
   logic [FRAC_W-1:0]       frac_s;
   logic signed [9:0]       exp_s;

   // Mantissa product, normalisation by one position, and special-case select
   always_comb begin
      sign_s = srca[FP_W-1] ^ srcb[FP_W-1];
      ea_s   = fp_exp(srca);
      eb_s   = fp_exp(srcb);
      prod_s = PROD_W'({1'b1, srca[FRAC_W-1:0]}) * PROD_W'({1'b1, srcb[FRAC_W-1:0]});
      // Product of two [1,2) mantissas lies in [1,4): the top bit picks the shift
      if (prod_s[PROD_W-1]) begin
         frac_s = FRAC_W'(prod_s >> MANT_W);
         exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_M1_S;
      end else begin
         frac_s = FRAC_W'(prod_s >> FRAC_W);
         exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;
      end
      // Zero classification takes priority over infinity
      if ((ea_s == EXP_ZERO) || (eb_s == EXP_ZERO) || (exp_s <= 10'sd0)) begin
         dst = FP_ZERO;
      end else if ((ea_s == EXP_MAX) || (eb_s == EXP_MAX) || (exp_s >= 10'sd255)) begin
         dst = {sign_s, FP_INF[FP_W-2:0]};
      end else begin
         dst = {sign_s, exp_s[EXP_W-1:0], frac_s};
      end
   end

endmodule

// File: rtl/fpu_mul_sched.sv
// ----------------------------------------------------------------------------
// fpu_mul_sched
// Two requester ports share one FP32 multiplier. One operation issues per
// cycle, round-robin under contention; each result returns on its own port
// exactly LATENCY cycles after issue, with no backpressure.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : fpu_mul_sched_if.slave (req0/req1 handshakes, rsp0/rsp1, busy)
// Parameters: LATENCY (2..8) issue-to-response cycles, TAGW tag width.
// ----------------------------------------------------------------------------
module fpu_mul_sched
   import fpu_mul_sched_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int TAGW    = 4
)
(
   input  logic            clk,
   input  logic            reset,
   fpu_mul_sched_if.slave  bus
);

   // Stages between the operand register and the response register
   localparam int PIPE_D = (LATENCY > 2) ? LATENCY - 2 : 1;

   port_id_t          last_grant_r;
   logic              grant0_s;
   logic              grant1_s;
   logic              issue_s;

   logic              iss_valid_r;
   port_id_t          iss_port_r;
   logic [TAGW-1:0]   iss_tag_r;
   logic [FP_W-1:0]   iss_srca_r;
   logic [FP_W-1:0]   iss_srcb_r;
   logic [FP_W-1:0]   core_dst_s;

   logic              tail_valid_s;
   port_id_t          tail_port_s;
   logic [TAGW-1:0]   tail_tag_s;
   logic [FP_W-1:0]   tail_dst_s;
   logic              pipe_busy_s;

   logic              rsp0_valid_r;
   logic [FP_W-1:0]   rsp0_dst_r;
   logic [TAGW-1:0]   rsp0_tag_r;
   logic              rsp1_valid_r;
   logic [FP_W-1:0]   rsp1_dst_r;
   logic [TAGW-1:0]   rsp1_tag_r;

   // Arbitration: lone requester wins, contention goes to the port not granted last
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (bus.req0_valid && bus.req1_valid) begin
         grant0_s = (last_grant_r == PORT1);
         grant1_s = (last_grant_r == PORT0);
      end else begin
         grant0_s = bus.req0_valid;
         grant1_s = bus.req1_valid;
      end
   end

   assign issue_s        = grant0_s | grant1_s;
   assign bus.req0_ready = grant0_s;
   assign bus.req1_ready = grant1_s;

   // Last-grant pointer, moved on every grant
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_r <= PORT1;
      end else if (issue_s) begin
         last_grant_r <= grant1_s ? PORT1 : PORT0;
      end
   end

   // Operand register: first in-flight stage
   always_ff @(posedge clk) begin
      if (reset) begin
         iss_valid_r <= 1'b0;
         iss_port_r  <= PORT0;
         iss_tag_r   <= {TAGW{1'b0}};
         iss_srca_r  <= 32'h0000_0000;
         iss_srcb_r  <= 32'h0000_0000;
      end else begin
         iss_valid_r <= issue_s;
         if (issue_s) begin
            iss_port_r <= grant1_s ? PORT1 : PORT0;
            iss_tag_r  <= grant1_s ? bus.req1_tag  : bus.req0_tag;
            iss_srca_r <= grant1_s ? bus.req1_srca : bus.req0_srca;
            iss_srcb_r <= grant1_s ? bus.req1_srcb : bus.req0_srcb;
         end
      end
   end

   fpu_mul_core u_core (
      .srca (iss_srca_r),
      .srcb (iss_srcb_r),
      .dst  (core_dst_s)
   );

   if (LATENCY > 2) begin : g_pipe
      logic            pipe_valid_r [PIPE_D];
      port_id_t        pipe_port_r  [PIPE_D];
      logic [TAGW-1:0] pipe_tag_r   [PIPE_D];
      logic [FP_W-1:0] pipe_dst_r   [PIPE_D];

      // Result shift chain; never stalls
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int k = 0; k < PIPE_D; k++) begin
               pipe_valid_r[k] <= 1'b0;
               pipe_port_r[k]  <= PORT0;
               pipe_tag_r[k]   <= {TAGW{1'b0}};
               pipe_dst_r[k]   <= 32'h0000_0000;
            end
         end else begin
            pipe_valid_r[0] <= iss_valid_r;
            pipe_port_r[0]  <= iss_port_r;
            pipe_tag_r[0]   <= iss_tag_r;
            pipe_dst_r[0]   <= core_dst_s;
            for (int k = 1; k < PIPE_D; k++) begin
               pipe_valid_r[k] <= pipe_valid_r[k-1];
               pipe_port_r[k]  <= pipe_port_r[k-1];
               pipe_tag_r[k]   <= pipe_tag_r[k-1];
               pipe_dst_r[k]   <= pipe_dst_r[k-1];
            end
         end
      end

      // Any valid entry in the result chain
      always_comb begin
         pipe_busy_s = 1'b0;
         for (int k = 0; k < PIPE_D; k++) begin
            pipe_busy_s = pipe_busy_s | pipe_valid_r[k];
         end
      end

      assign tail_valid_s = pipe_valid_r[PIPE_D-1];
      assign tail_port_s  = pipe_port_r[PIPE_D-1];
      assign tail_tag_s   = pipe_tag_r[PIPE_D-1];
      assign tail_dst_s   = pipe_dst_r[PIPE_D-1];
   end else begin : g_direct
      assign tail_valid_s = iss_valid_r;
      assign tail_port_s  = iss_port_r;
      assign tail_tag_s   = iss_tag_r;
      assign tail_dst_s   = core_dst_s;
      assign pipe_busy_s  = 1'b0;
   end

   // Response registers: the final chain stage, split per port; data holds between pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid_r <= 1'b0;
         rsp0_dst_r   <= 32'h0000_0000;
         rsp0_tag_r   <= {TAGW{1'b0}};
         rsp1_valid_r <= 1'b0;
         rsp1_dst_r   <= 32'h0000_0000;
         rsp1_tag_r   <= {TAGW{1'b0}};
      end else begin
         rsp0_valid_r <= tail_valid_s && (tail_port_s == PORT0);
         rsp1_valid_r <= tail_valid_s && (tail_port_s == PORT1);
         if (tail_valid_s && (tail_port_s == PORT0)) begin
            rsp0_dst_r <= tail_dst_s;
            rsp0_tag_r <= tail_tag_s;
         end
         if (tail_valid_s && (tail_port_s == PORT1)) begin
            rsp1_dst_r <= tail_dst_s;
            rsp1_tag_r <= tail_tag_s;
         end
      end
   end

   assign bus.rsp0_valid = rsp0_valid_r;
   assign bus.rsp0_dst   = rsp0_dst_r;
   assign bus.rsp0_tag   = rsp0_tag_r;
   assign bus.rsp1_valid = rsp1_valid_r;
   assign bus.rsp1_dst   = rsp1_dst_r;
   assign bus.rsp1_tag   = rsp1_tag_r;
   assign bus.busy       = iss_valid_r | pipe_busy_s | rsp0_valid_r | rsp1_valid_r;

endmodule

// File: tb/tb_fpu_mul_sched.sv
// ----------------------------------------------------------------------------
// tb_fpu_mul_sched
// Self-checking bench for fpu_mul_sched: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_fpu_mul_sched;

   localparam int TAGW = 4;
   localparam int LAT  = 3;
   localparam int LOGN = 16384;

   typedef struct {
      int              due;
      logic [TAGW-1:0] tag;
      logic [31:0]     dst;
   } rsp_t;

   logic clk;
   logic reset;

   fpu_mul_sched_if #(.TAGW(TAGW)) bus ();

   fpu_mul_sched #(.LATENCY(LAT), .TAGW(TAGW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int              n_assert = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   rsp_t            q0[$];
   rsp_t            q1[$];
   logic            m_last   = 1'b1;
   logic [31:0]     m_dst0   = 32'h0;
   logic [31:0]     m_dst1   = 32'h0;
   logic [TAGW-1:0] m_tag0   = '0;
   logic [TAGW-1:0] m_tag1   = '0;
   logic            last_g0  = 1'b0;
   logic            last_g1  = 1'b0;
   int              wait0    = 0;
   int              wait1    = 0;

   logic            lg_v0   [LOGN];
   logic            lg_v1   [LOGN];
   logic            lg_busy [LOGN];
   logic [31:0]     lg_d0   [LOGN];
   logic [31:0]     lg_d1   [LOGN];
   logic [TAGW-1:0] lg_t0   [LOGN];
   logic [TAGW-1:0] lg_t1   [LOGN];

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
      end
   endtask

   // Reference FP32 multiply from the arithmetic rules, using plain integers
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int              ea;
      int              eb;
      int              e;
      longint unsigned ma;
      longint unsigned mb;
      longint unsigned prod;
      longint unsigned frac;
      logic            s;
      ea   = int'(a[30:23]);
      eb   = int'(b[30:23]);
      s    = a[31] ^ b[31];
      ma   = 64'h80_0000 + 64'(a[22:0]);
      mb   = 64'h80_0000 + 64'(b[22:0]);
      prod = ma * mb;
      if (prod >= (64'd1 << 47)) begin
         frac = (prod >> 24) % (64'd1 << 23);
         e    = ea + eb - 126;
      end else begin
         frac = (prod >> 23) % (64'd1 << 23);
         e    = ea + eb - 127;
      end
      if (ea == 0 || eb == 0 || e <= 0) return 32'h0000_0000;
      if (ea == 255 || eb == 255 || e >= 255) return {s, 31'h7F80_0000};
      return {s, 8'(e), 23'(frac)};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic       s;
      logic [7:0] e;
      logic [22:0] f;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) e = 8'($urandom_range(0, 255));
      else                           e = 8'($urandom_range(100, 154));
      f = 23'($urandom);
      return {s, e, f};
   endfunction

   // One clock cycle: check outputs against the model mid-cycle, then advance it
   task automatic cycle();
      logic exp_g0;
      logic exp_g1;
      logic exp_busy;
      rsp_t e;
      @(negedge clk);
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (!reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            exp_g0 = (m_last == 1'b1);
            exp_g1 = !exp_g0;
         end else begin
            exp_g0 = bus.req0_valid;
            exp_g1 = bus.req1_valid;
         end
      end
      check("req0_ready", 32'(bus.req0_ready), 32'(exp_g0));
      check("req1_ready", 32'(bus.req1_ready), 32'(exp_g1));
      exp_busy = (q0.size() != 0) || (q1.size() != 0);
      check("busy", 32'(bus.busy), 32'(exp_busy));

      if (q0.size() != 0 && q0[0].due == cyc) begin
         e = q0.pop_front();
         m_dst0 = e.dst;
         m_tag0 = e.tag;
         check("rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      end else begin
         check("rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      end
      check("rsp0_dst", bus.rsp0_dst, m_dst0);
      check("rsp0_tag", 32'(bus.rsp0_tag), 32'(m_tag0));

      if (q1.size() != 0 && q1[0].due == cyc) begin
         e = q1.pop_front();
         m_dst1 = e.dst;
         m_tag1 = e.tag;
         check("rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      end else begin
         check("rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      end
      check("rsp1_dst", bus.rsp1_dst, m_dst1);
      check("rsp1_tag", 32'(bus.rsp1_tag), 32'(m_tag1));

      lg_v0[cyc]   = bus.rsp0_valid;
      lg_v1[cyc]   = bus.rsp1_valid;
      lg_d0[cyc]   = bus.rsp0_dst;
      lg_d1[cyc]   = bus.rsp1_dst;
      lg_t0[cyc]   = bus.rsp0_tag;
      lg_t1[cyc]   = bus.rsp1_tag;
      lg_busy[cyc] = bus.busy;

      if (!reset && bus.req0_valid && bus.req1_valid) begin
         if (bus.req0_ready) wait0 = 0; else wait0++;
         if (bus.req1_ready) wait1 = 0; else wait1++;
         check("starve0", 32'(wait0 <= 1), 32'd1);
         check("starve1", 32'(wait1 <= 1), 32'd1);
      end else begin
         wait0 = 0;
         wait1 = 0;
      end

      if (exp_g0) begin
         e.due = cyc + LAT;
         e.tag = bus.req0_tag;
         e.dst = ref_mul(bus.req0_srca, bus.req0_srcb);
         q0.push_back(e);
         m_last = 1'b0;
      end
      if (exp_g1) begin
         e.due = cyc + LAT;
         e.tag = bus.req1_tag;
         e.dst = ref_mul(bus.req1_srca, bus.req1_srcb);
         q1.push_back(e);
         m_last = 1'b1;
      end
      last_g0 = exp_g0;
      last_g1 = exp_g1;
      if (reset) begin
         q0.delete();
         q1.delete();
         m_last = 1'b1;
         m_dst0 = 32'h0;
         m_dst1 = 32'h0;
         m_tag0 = '0;
         m_tag1 = '0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   logic [31:0] ops_a [3];
   logic [31:0] ops_b [3];
   logic [31:0] ops_r [3];
   int          n;

   initial begin
      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_srca  = 32'h0;
      bus.req0_srcb  = 32'h0;
      bus.req0_tag   = '0;
      bus.req1_valid = 1'b0;
      bus.req1_srca  = 32'h0;
      bus.req1_srcb  = 32'h0;
      bus.req1_tag   = '0;
      @(posedge clk);
      #1;

      // Reset state, with valids raised to confirm readys stay low in reset
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      cycle();
      check("reset_busy", 32'(lg_busy[0]), 32'd0);
      check("reset_rsp0_dst", lg_d0[0], 32'h0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      reset = 1'b0;

      // Contention right after reset: grants 0,1,0,1
      n = cyc;
      bus.req0_valid = 1'b1; bus.req0_srca = 32'h4000_0000; bus.req0_srcb = 32'h4040_0000; bus.req0_tag = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_srca = 32'h3FC0_0000; bus.req1_srcb = 32'h3FC0_0000; bus.req1_tag = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("alt_ready0", 32'(bus.req0_ready), 32'((i % 2) == 0));
         check("alt_ready1", 32'(bus.req1_ready), 32'((i % 2) == 1));
         cycle();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      for (int i = 0; i < LAT + 1; i++) cycle();
      for (int i = 0; i < 4; i++) begin
         if ((i % 2) == 0) begin
            check("alt_rsp0_v", 32'(lg_v0[n+LAT+i]), 32'd1);
            check("alt_rsp0_d", lg_d0[n+LAT+i], 32'h40C0_0000);
            check("alt_rsp1_v", 32'(lg_v1[n+LAT+i]), 32'd0);
         end else begin
            check("alt_rsp1_v", 32'(lg_v1[n+LAT+i]), 32'd1);
            check("alt_rsp1_d", lg_d1[n+LAT+i], 32'h4010_0000);
            check("alt_rsp0_v", 32'(lg_v0[n+LAT+i]), 32'd0);
         end
      end

      // Port 0 alone: 1.0 * 1.0 with tag 5
      n = cyc;
      bus.req0_valid = 1'b1; bus.req0_srca = 32'h3F80_0000; bus.req0_srcb = 32'h3F80_0000; bus.req0_tag = 4'd5;
      cycle();
      bus.req0_valid = 1'b0;
      for (int i = 0; i < LAT + 1; i++) cycle();
      check("one_rsp0_early", 32'(lg_v0[n+LAT-1]), 32'd0);
      check("one_rsp0_v", 32'(lg_v0[n+LAT]), 32'd1);
      check("one_rsp0_d", lg_d0[n+LAT], 32'h3F80_0000);
      check("one_rsp0_t", 32'(lg_t0[n+LAT]), 32'd5);
      check("one_rsp1_v", 32'(lg_v1[n+LAT]), 32'd0);

      // Overflow and underflow boundaries on port 1
      ops_a[0] = 32'h7F00_0000; ops_b[0] = 32'h7F00_0000; ops_r[0] = 32'h7F80_0000;
      ops_a[1] = 32'hFF00_0000; ops_b[1] = 32'h7F00_0000; ops_r[1] = 32'hFF80_0000;
      ops_a[2] = 32'h0080_0000; ops_b[2] = 32'h0080_0000; ops_r[2] = 32'h0000_0000;
      n = cyc;
      for (int i = 0; i < 3; i++) begin
         bus.req1_valid = 1'b1; bus.req1_srca = ops_a[i]; bus.req1_srcb = ops_b[i]; bus.req1_tag = 4'(i + 8);
         cycle();
      end
      bus.req1_valid = 1'b0;
      for (int i = 0; i < LAT + 1; i++) cycle();
      for (int i = 0; i < 3; i++) begin
         check("edge_rsp1_v", 32'(lg_v1[n+LAT+i]), 32'd1);
         check("edge_rsp1_d", lg_d1[n+LAT+i], ops_r[i]);
      end

      // Three issues, then reset one cycle later discards what is in flight
      n = cyc;
      for (int i = 0; i < 3; i++) begin
         bus.req0_valid = 1'b1; bus.req0_srca = rand_fp(); bus.req0_srcb = rand_fp(); bus.req0_tag = 4'(i);
         cycle();
      end
      bus.req0_valid = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) cycle();
      check("rst_busy", 32'(lg_busy[n+4]), 32'd0);
      for (int i = 4; i < LAT + 6; i++) begin
         check("rst_no_rsp0", 32'(lg_v0[n+i]), 32'd0);
         check("rst_no_rsp1", 32'(lg_v1[n+i]), 32'd0);
      end
      bus.req0_valid = 1'b1; bus.req0_srca = 32'h3F80_0000; bus.req0_srcb = 32'h4000_0000; bus.req0_tag = 4'd3;
      bus.req1_valid = 1'b1; bus.req1_srca = 32'h4000_0000; bus.req1_srcb = 32'h4000_0000; bus.req1_tag = 4'd4;
      #1;
      check("rst_grant0", 32'(bus.req0_ready), 32'd1);
      check("rst_grant1", 32'(bus.req1_ready), 32'd0);
      cycle();
      bus.req0_valid = 1'b0;

      // Random traffic; a requester holds its operation until accepted
      for (int i = 0; i < 10000; i++) begin
         if (!bus.req0_valid || last_g0) begin
            if ($urandom_range(0, 3) != 0) begin
               bus.req0_valid = 1'b1;
               bus.req0_srca  = rand_fp();
               bus.req0_srcb  = rand_fp();
               bus.req0_tag   = TAGW'($urandom);
            end else begin
               bus.req0_valid = 1'b0;
            end
         end
         if (!bus.req1_valid || last_g1) begin
            if ($urandom_range(0, 3) != 0) begin
               bus.req1_valid = 1'b1;
               bus.req1_srca  = rand_fp();
               bus.req1_srcb  = rand_fp();
               bus.req1_tag   = TAGW'($urandom);
            end else begin
               bus.req1_valid = 1'b0;
            end
         end
         cycle();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      for (int i = 0; i < LAT + 2; i++) cycle();
      check("drain_q0", 32'(q0.size()), 32'd0);
      check("drain_q1", 32'(q1.size()), 32'd0);
      check("drain_busy", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
